// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding.
// Encoding 2'd3 is unused and treated as IDLE by every decoder.
package serial_subtractor_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one bit per clock, LSB first,
// with valid/ready on both the operand and the result side.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, nstate;
   logic [WIDTH-1:0] sa, sb, res;
   logic [CW-1:0]    cnt;
   logic             bf, asg, bsg;
   logic             accept, busy, last, dbit, bout;

   full_subtractor u_fs (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (bf),
      .d    (dbit),
      .bout (bout)
   );

   assign busy   = (state == ST_BUSY);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         ST_BUSY: if (last)      nstate = ST_DONE;
         ST_DONE: if (out_ready) nstate = ST_IDLE;
         default: nstate = in_valid ? ST_BUSY : ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_BUSY: ;
         ST_DONE: out_valid = 1'b1;
         default: in_ready  = 1'b1;
      endcase
   end

   // Difference bits enter at the MSB so the result lands LSB-aligned after WIDTH steps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sa  <= '0;
         sb  <= '0;
         res <= '0;
         cnt <= '0;
         bf  <= 1'b0;
         asg <= 1'b0;
         bsg <= 1'b0;
      end else if (accept) begin
         sa  <= a;
         sb  <= b;
         cnt <= '0;
         bf  <= 1'b0;
         asg <= a[WIDTH-1];
         bsg <= b[WIDTH-1];
      end else if (busy) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         res <= {dbit, res[WIDTH-1:1]};
         bf  <= bout;
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

   assign diff     = res;
   assign borrow   = bf;
   assign overflow = (asg ^ bsg) & (res[WIDTH-1] ^ asg);
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a negedge monitor compares whatever the DUT presents.
module tb_serial_subtractor;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_acc = 0;
   exp_t q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   sx, sy, sd;
      sx = int'($signed(x));
      sy = int'($signed(y));
      sd = sx - sy;
      e.diff   = W'(int'(x) - int'(y));
      e.borrow = (int'(x) < int'(y));
      e.ovf    = (sd > 32767) || (sd < -32768);
      e.acc    = 0;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      a = x;
      b = y;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk(1'b0, "accept_timeout", 0, 1);
      end else begin
         e = model(x, y);
         e.acc = cyc + 1;
         last_acc = e.acc;
         q.push_back(e);
         @(posedge clk); #1;
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(q.size() == 0, "drain_timeout", q.size(), 0);
   endtask

   // Monitor
   bit seen = 1'b0;
   bit hs_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         seen    = 1'b0;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) chk(in_ready === 1'b1, "in_ready_after_hs", in_ready, 1);
         hs_prev = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_result", diff, 0);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  chk(cyc - q[0].acc == W, "latency", cyc - q[0].acc, W);
               end
               chk(diff === q[0].diff, "diff", diff, q[0].diff);
               chk(borrow === q[0].borrow, "borrow", borrow, q[0].borrow);
               chk(overflow === q[0].ovf, "overflow", overflow, q[0].ovf);
               chk(in_ready === 1'b0, "in_ready_in_done", in_ready, 0);
               if (out_ready) begin
                  void'(q.pop_front());
                  seen    = 1'b0;
                  hs_prev = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, prev;
      logic [W-1:0] x, y;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
      chk(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
      chk(diff === '0, "rst_diff", diff, 0);
      chk({borrow, overflow} === 2'b00, "rst_flags", {borrow, overflow}, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk(in_ready === 1'b1, "post_rst_in_ready", in_ready, 1);
      chk(out_valid === 1'b0, "post_rst_out_valid", out_valid, 0);

      // Directed arithmetic corners
      send(16'd5, 16'd3, 0);        drain();
      send(16'd3, 16'd5, 0);        drain();
      send(16'h8000, 16'h0001, 0);  drain();
      send(16'h7FFF, 16'hFFFF, 0);  drain();
      send(16'h0000, 16'h0000, 0);  drain();

      // Stall in DONE with noisy inputs
      out_ready = 1'b0;
      send(16'h1234, 16'h4321, 0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(out_valid === 1'b1, "stall_reach_done", out_valid, 1);
      repeat (10) begin
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Asynchronous reset after 7 bit steps
      send(16'hBEEF, 16'h1357, 0);
      repeat (7) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      q.delete();
      chk(out_valid === 1'b0, "abort_out_valid", out_valid, 0);
      chk(diff === '0, "abort_diff", diff, 0);
      chk(in_ready === 1'b1, "abort_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk(in_ready === 1'b1, "release_in_ready", in_ready, 1);
      send(16'd9, 16'd9, 0);
      drain();

      // Back-to-back random operations, in_valid held high
      prev = -1;
      for (int i = 0; i < 100; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         if (i % 10 == 0) y = x;
         send(x, y, 1);
         if (prev >= 0) chk(last_acc - prev == W + 2, "period", last_acc - prev, W + 2);
         prev = last_acc;
      end
      in_valid = 1'b0;
      drain();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor. It accepts two WIDTH-bit operands through a valid/ready handshake and computes a − b one bit per clock, LSB first, using a single bit-level full subtractor and a borrow flip-flop. It returns the difference, the final borrow and the signed-overflow flag through a second valid/ready handshake. It is the small-area counterpart to the ripple adder chain in the ALU datapath, for slow paths where one subtract per WIDTH cycles is enough.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock, no other clock domains
- in_valid  input  1  operands a, b are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes the result
- diff  output  WIDTH  a − b mod 2^WIDTH
- borrow  output  1  final borrow out; 1 iff a < b unsigned
- overflow  output  1  signed overflow of a − b

## Operation
States: IDLE, BUSY, DONE, encoded in 2 bits.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture a and b into shift registers, clear the borrow flop, clear the bit counter, capture the sign bits a[WIDTH-1] and b[WIDTH-1], and go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge feeds the LSBs of the a and b shift registers and the borrow flop into full_subtractor.
  - The difference bit shifts into the MSB of the result register, which shifts right. The borrow flop takes borrow-out. Both operand registers shift right.
  - The counter increments each edge. On the edge where the counter equals WIDTH−1, go to DONE.
- DONE:
  - out_valid = 1.
  - diff, borrow and overflow are held stable.
  - On out_valid & out_ready, go to IDLE.
- Arithmetic rules:
  - diff = (a − b) mod 2^WIDTH.
  - borrow = borrow flop after the MSB step.
  - overflow = (a_sign ≠ b_sign) & (diff[WIDTH-1] ≠ a_sign).
- Input handling:
  - a and b are sampled only at the accept edge; changes afterwards are ignored.
  - in_valid outside IDLE is ignored, not queued.
- Reset (asynchronous):
  - Forces IDLE, clears all registers and the counter.
  - A reset during BUSY or DONE aborts the operation; no result is produced.
- Outputs during reset and after release: in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0.

## Timing
- Accept edge E0. out_valid rises after edge E0+WIDTH, so latency is WIDTH cycles from accept to result.
- out_valid and in_ready are decoded directly from state; no combinational path from in_valid or out_ready to any output.
- Output handshake at edge Ed:
  - in_ready is 1 in the following cycle.
  - No same-cycle turnaround: minimum operation period is WIDTH+2 cycles with out_ready held high.
- out_ready low in DONE stalls indefinitely with outputs unchanged.
- Counter width is clog2(WIDTH); it wraps only through the DONE transition, never free-running.

## Structure
- Shared header (team constants include):
  - State encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - Unused encoding 2'd3 decodes to IDLE.
- One sub-module, full_subtractor(a, b, bin, d, bout):
  - d = a^b^bin.
  - bout = (~a&b) | (~(a^b)&bin).
  - Combinational, instantiated once.
- Top level holds the FSM, the counter, the three shift registers, the borrow flop and the sign flops.

## Test plan
- WIDTH=16, a=5, b=3, out_ready=1 → out_valid 16 cycles after accept; diff=0x0002, borrow=0, overflow=0; in_ready high 1 cycle after output handshake.
- a=3, b=5 → diff=0xFFFE, borrow=1, overflow=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, borrow=0, overflow=1. Also a=0x7FFF, b=0xFFFF → diff=0x8000, borrow=1, overflow=1.
- out_ready held low 10 cycles in DONE, with a and b toggled and in_valid=1 → diff, borrow and overflow unchanged, in_ready=0, no new accept; result consumed when out_ready rises.
- Reset asserted asynchronously mid-BUSY after 7 bit steps → out_valid=0 and diff=0 immediately, no result emitted. After release, in_ready=1, and a new 9−9 produces diff=0, borrow=0.
- Back-to-back operations, in_valid held high, 100 random pairs → each result equals a−b mod 2^16 with correct borrow/overflow; period exactly 18 cycles.
